// File: rtl/spio_status_led_shifter_pkg.sv
// Shared definitions for the status LED shift-register driver.
// Holds the frame-scheduler state encodings and a small state helper.
package spio_status_led_shifter_pkg;

    localparam int unsigned STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] STATE_IDLE  = 3'd0;
    localparam logic [STATE_BITS-1:0] STATE_LOAD  = 3'd1;
    localparam logic [STATE_BITS-1:0] STATE_SETUP = 3'd2;
    localparam logic [STATE_BITS-1:0] STATE_HOLD  = 3'd3;
    localparam logic [STATE_BITS-1:0] STATE_LATCH = 3'd4;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_LOAD  = STATE_LOAD,
        ST_SETUP = STATE_SETUP,
        ST_HOLD  = STATE_HOLD,
        ST_LATCH = STATE_LATCH
    } state_t;

    // States whose duration is paced by the clock divider.
    function automatic logic is_timed_state(input state_t s);
        return (s == ST_SETUP) || (s == ST_HOLD) || (s == ST_LATCH);
    endfunction

endpackage

// File: rtl/spio_status_led_shifter_div.sv
// Phase-length counter: counts 0..CLK_DIV-1, clears synchronously, flags the
// terminal count now and whether the next count will be terminal.
module spio_status_led_shifter_div #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned CLK_DIV_BITS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc_c,
    output logic next_tc_c
);

    localparam logic [CLK_DIV_BITS-1:0] LAST = CLK_DIV_BITS'(CLK_DIV - 1);

    logic [CLK_DIV_BITS-1:0] cnt;
    logic [CLK_DIV_BITS-1:0] cnt_next;

    assign tc_c      = (cnt == LAST);
    assign next_tc_c = (cnt_next == LAST);

    always_comb begin
        cnt_next = cnt + CLK_DIV_BITS'(1);
        if (clr || tc_c) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/spio_status_led_shifter.sv
// Serialises an LED vector onto a 74HC595-style chain (SCLK/SDATA/LATCH),
// running snapshot/shift/latch frames back-to-back while enabled.
module spio_status_led_shifter
    import spio_status_led_shifter_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned CLK_DIV_BITS   = 3,
    parameter int unsigned BIT_CNT_BITS   = 3,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                ENABLE_IN,
    input  logic [NUM_LEDS-1:0] LED_IN,
    output logic                SCLK_OUT,
    output logic                SDATA_OUT,
    output logic                LATCH_OUT,
    output logic                BUSY_OUT,
    output logic                FRAME_DONE_OUT
);

    localparam logic [BIT_CNT_BITS-1:0] FIRST_BIT = BIT_CNT_BITS'(NUM_LEDS - 1);

    state_t                  state;
    state_t                  next_state;
    logic [NUM_LEDS-1:0]     shadow;
    logic [NUM_LEDS-1:0]     next_shadow;
    logic [BIT_CNT_BITS-1:0] bit_cnt;
    logic [BIT_CNT_BITS-1:0] next_bit_cnt;

    logic div_clr;
    logic div_tc_c;
    logic div_next_tc_c;

    logic sclk_next;
    logic sdata_next;
    logic latch_next;
    logic busy_next;
    logic done_next;

    // Divider restarts on every state change and idles outside timed states.
    assign div_clr = (next_state != state) || !is_timed_state(next_state);

    spio_status_led_shifter_div #(
        .CLK_DIV      (CLK_DIV),
        .CLK_DIV_BITS (CLK_DIV_BITS)
    ) u_div (
        .clk       (CLK_IN),
        .rst_n     (RESET_IN),
        .clr       (div_clr),
        .tc_c      (div_tc_c),
        .next_tc_c (div_next_tc_c)
    );

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            shadow  <= next_shadow;
            bit_cnt <= next_bit_cnt;
        end
    end

    // Frame scheduler; outputs are derived from the state about to be occupied.
    always_comb begin
        next_state   = state;
        next_shadow  = shadow;
        next_bit_cnt = bit_cnt;

        case (state)
            ST_IDLE: begin
                if (ENABLE_IN) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                next_shadow  = LED_IN;
                next_bit_cnt = FIRST_BIT;
                next_state   = ST_SETUP;
            end
            ST_SETUP: begin
                if (div_tc_c) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (div_tc_c) begin
                    if (bit_cnt == '0) begin
                        next_state = ST_LATCH;
                    end else begin
                        next_bit_cnt = bit_cnt - BIT_CNT_BITS'(1);
                        next_state   = ST_SETUP;
                    end
                end
            end
            ST_LATCH: begin
                if (div_tc_c) begin
                    next_state = ENABLE_IN ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        sclk_next  = (next_state == ST_HOLD);
        sdata_next = 1'b0;
        if ((next_state == ST_SETUP) || (next_state == ST_HOLD)) begin
            sdata_next = next_shadow[next_bit_cnt] ^ LED_ACTIVE_LOW;
        end
        latch_next = (next_state == ST_LATCH);
        busy_next  = (next_state != ST_IDLE);
        done_next  = (next_state == ST_LATCH) && div_next_tc_c;
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            SCLK_OUT       <= 1'b0;
            SDATA_OUT      <= 1'b0;
            LATCH_OUT      <= 1'b0;
            BUSY_OUT       <= 1'b0;
            FRAME_DONE_OUT <= 1'b0;
        end else begin
            SCLK_OUT       <= sclk_next;
            SDATA_OUT      <= sdata_next;
            LATCH_OUT      <= latch_next;
            BUSY_OUT       <= busy_next;
            FRAME_DONE_OUT <= done_next;
        end
    end

endmodule

// File: tb/tb_spio_status_led_shifter.sv
// Scoreboard bench: a frame-position model predicts control outputs per cycle
// and queues each frame's snapshot; a monitor reassembles shifted bits per frame.
module tb_spio_status_led_shifter;

    localparam int unsigned N = 4;
    localparam int unsigned D = 2;
    localparam int FRAME     = 1 + (2 * N + 1) * D;
    localparam int SHIFT_END = 1 + 2 * N * D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         en    = 1'b0;
    logic [N-1:0] led   = '0;

    logic sclk_a, sdata_a, latch_a, busy_a, done_a;
    logic sclk_b, sdata_b, latch_b, busy_b, done_b;

    spio_status_led_shifter #(
        .NUM_LEDS(N), .CLK_DIV(D), .CLK_DIV_BITS(1), .BIT_CNT_BITS(2), .LED_ACTIVE_LOW(1'b0)
    ) dut_a (
        .CLK_IN(clk), .RESET_IN(rst_n), .ENABLE_IN(en), .LED_IN(led),
        .SCLK_OUT(sclk_a), .SDATA_OUT(sdata_a), .LATCH_OUT(latch_a),
        .BUSY_OUT(busy_a), .FRAME_DONE_OUT(done_a)
    );

    spio_status_led_shifter #(
        .NUM_LEDS(N), .CLK_DIV(D), .CLK_DIV_BITS(1), .BIT_CNT_BITS(2), .LED_ACTIVE_LOW(1'b1)
    ) dut_b (
        .CLK_IN(clk), .RESET_IN(rst_n), .ENABLE_IN(en), .LED_IN(led),
        .SCLK_OUT(sclk_b), .SDATA_OUT(sdata_b), .LATCH_OUT(latch_b),
        .BUSY_OUT(busy_b), .FRAME_DONE_OUT(done_b)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           pos    = 0;
    logic [N-1:0] exp_q[$];

    // Reference: position within the frame (0 = idle, 1 = snapshot cycle, FRAME = last).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 0;
        end else begin
            if (pos == 1) begin
                exp_q.push_back(led);
            end
            if (pos == 0 || pos == FRAME) begin
                pos <= en ? 1 : 0;
            end else begin
                pos <= pos + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t (pos %0d)", name, got, exp, $time, pos);
        end
    endtask

    // Monitor: per-cycle control checks plus frame reassembly against the queue.
    initial begin : monitor
        logic [N-1:0] bits_a, bits_b, e;
        int           nbits_a, nbits_b;
        logic         prev_a, prev_b;
        logic         exp_sclk, exp_latch, exp_busy, exp_done, in_shift;
        bits_a = '0; bits_b = '0; nbits_a = 0; nbits_b = 0; prev_a = 1'b0; prev_b = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                chk("reset_outputs_a", {11'd0, sclk_a, sdata_a, latch_a, busy_a, done_a}, 16'd0);
                chk("reset_outputs_b", {11'd0, sclk_b, sdata_b, latch_b, busy_b, done_b}, 16'd0);
                exp_q.delete();
                bits_a = '0; bits_b = '0; nbits_a = 0; nbits_b = 0; prev_a = 1'b0; prev_b = 1'b0;
            end else begin
                in_shift  = (pos >= 2) && (pos <= SHIFT_END);
                exp_sclk  = in_shift && ((((pos - 2) / D) % 2) == 1);
                exp_latch = (pos > SHIFT_END);
                exp_busy  = (pos != 0);
                exp_done  = (pos == FRAME);
                chk("ctrl_a", {12'd0, sclk_a, latch_a, busy_a, done_a},
                    {12'd0, exp_sclk, exp_latch, exp_busy, exp_done});
                chk("ctrl_b", {12'd0, sclk_b, latch_b, busy_b, done_b},
                    {12'd0, exp_sclk, exp_latch, exp_busy, exp_done});
                if (!in_shift) begin
                    chk("sdata_quiet", {14'd0, sdata_a, sdata_b}, 16'd0);
                end
                if (sclk_a && !prev_a) begin
                    bits_a = {bits_a[N-2:0], sdata_a};
                    nbits_a++;
                end
                if (sclk_b && !prev_b) begin
                    bits_b = {bits_b[N-2:0], sdata_b};
                    nbits_b++;
                end
                prev_a = sclk_a;
                prev_b = sclk_b;
                if (done_a) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got frame %0h with no expected frame at %0t",
                                 bits_a, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_a", {8'd0, 4'(nbits_a), bits_a}, {8'd0, 4'(N), e});
                        chk("frame_b", {8'd0, 4'(nbits_b), bits_b}, {8'd0, 4'(N), ~e});
                    end
                    bits_a = '0; bits_b = '0; nbits_a = 0; nbits_b = 0;
                end
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) return;
        end
        $display("FAIL wait_done: got no FRAME_DONE_OUT within 200 cycles, expected one at %0t", $time);
        $fatal(1);
    endtask

    initial begin : stimulus
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back frames with LED changes landing mid-shift.
        led = 4'b1010;
        en  = 1'b1;
        repeat (8) @(negedge clk);
        led = 4'b0101;
        wait_done();
        repeat (5) @(negedge clk);
        led = 4'b1100;
        wait_done();
        wait_done();

        // Drop enable during the second bit; frame must still finish.
        repeat (7) @(negedge clk);
        en = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        // Reset while SCLK is high in the first bit's HOLD phase.
        led = 4'b1001;
        en  = 1'b1;
        wait_done();
        led = 4'b0110;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        led = 4'b1011;
        wait_done();

        // Randomised LED churn and enable toggling.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) led = N'($urandom);
            if ($urandom_range(0, 39) == 0) en = ~en;
        end

        en = 1'b0;
        repeat (FRAME + 6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
